// File: rtl/simple_bus_pkg.sv
// Shared types and defaults for the simple_bus initiator.
// Holds the transaction FSM state encoding and the default command width and timeout.
package simple_bus_pkg;

  localparam int CMD_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    REARM = 3'd4
  } state_t;

endpackage

// File: rtl/simple_bus_req_fifo.sv
// Request queue for the simple_bus initiator.
// The head entry is visible on dout while the queue is non-empty.
module simple_bus_req_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // The extra pointer bit tells a full queue apart from an empty one.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign dout = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/simple_bus_master.sv
// simple_bus initiator: queues commands, strobes them to the responder, waits for
// done or timeout, reports upstream, then re-arms the responder with bus_rst.
module simple_bus_master
  import simple_bus_pkg::*;
#(
  parameter int CMD_W      = CMD_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CMD_W-1:0] req_cmd,
  output logic             rsp_valid,
  output logic [CMD_W-1:0] rsp_cmd,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             bus_en,
  output logic [CMD_W-1:0] bus_cmd,
  input  logic             bus_done,
  output logic             bus_rst,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_reg, state_next;
  logic [CMD_W-1:0] cur_cmd_reg, cur_cmd_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic [CMD_W-1:0] rsp_cmd_reg, rsp_cmd_next;
  logic             rsp_timeout_reg, rsp_timeout_next;
  logic [CNT_W-1:0] rsp_cycles_reg, rsp_cycles_next;
  logic             done_q_reg;
  logic             done_rise;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_dout;

  simple_bus_req_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (fifo_pop),
    .din   (req_cmd),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A done level already present at issue never produces an edge, so an
  // un-rearmed responder surfaces as a timeout.
  assign done_rise = bus_done && !done_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cur_cmd_reg     <= '0;
      counter_reg     <= '0;
      rsp_cmd_reg     <= '0;
      rsp_timeout_reg <= 1'b0;
      rsp_cycles_reg  <= '0;
      done_q_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cur_cmd_reg     <= cur_cmd_next;
      counter_reg     <= counter_next;
      rsp_cmd_reg     <= rsp_cmd_next;
      rsp_timeout_reg <= rsp_timeout_next;
      rsp_cycles_reg  <= rsp_cycles_next;
      done_q_reg      <= bus_done;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cur_cmd_next     = cur_cmd_reg;
    counter_next     = counter_reg;
    rsp_cmd_next     = rsp_cmd_reg;
    rsp_timeout_next = rsp_timeout_reg;
    rsp_cycles_next  = rsp_cycles_reg;
    fifo_pop         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          cur_cmd_next = fifo_dout;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        counter_next = CNT_W'(1);
        state_next   = WAIT;
      end
      WAIT: begin
        // done is checked first so a rise on the last allowed cycle still counts.
        if (done_rise) begin
          rsp_cmd_next     = cur_cmd_reg;
          rsp_cycles_next  = counter_reg;
          rsp_timeout_next = 1'b0;
          state_next       = RESP;
        end else if (counter_reg == TIMEOUT_C) begin
          rsp_cmd_next     = cur_cmd_reg;
          rsp_cycles_next  = TIMEOUT_C;
          rsp_timeout_next = 1'b1;
          state_next       = RESP;
        end else begin
          counter_next = counter_reg + CNT_W'(1);
        end
      end
      RESP:    state_next = REARM;
      REARM:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready   = !fifo_full;
  assign bus_en      = (state_reg == ISSUE);
  assign bus_cmd     = cur_cmd_reg;
  assign bus_rst     = rst || (state_reg == REARM);
  assign rsp_valid   = (state_reg == RESP);
  assign rsp_cmd     = rsp_cmd_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign rsp_cycles  = rsp_cycles_reg;
  assign busy        = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_simple_bus_master.sv
// Directed bench for simple_bus_master with a sticky-done responder model.
// Latency 0 in the model means the responder never raises done.
module tb_simple_bus_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_cmd;
  logic       rsp_valid;
  logic [3:0] rsp_cmd;
  logic       rsp_timeout;
  logic [7:0] rsp_cycles;
  logic       bus_en;
  logic [3:0] bus_cmd;
  logic       bus_done;
  logic       bus_rst;
  logic       busy;

  int tests = 0;
  int fails = 0;

  simple_bus_master dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .rsp_valid   (rsp_valid),
    .rsp_cmd     (rsp_cmd),
    .rsp_timeout (rsp_timeout),
    .rsp_cycles  (rsp_cycles),
    .bus_en      (bus_en),
    .bus_cmd     (bus_cmd),
    .bus_done    (bus_done),
    .bus_rst     (bus_rst),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Responder model: done goes high lat cycles after the bus_en cycle and
  // stays high until bus_rst; stuck forces done high regardless.
  int   lat   = 0;
  logic stuck = 1'b0;
  logic done_r = 1'b0;
  logic act    = 1'b0;
  int   mcnt   = 0;

  assign bus_done = stuck || done_r;

  always @(posedge clk) begin
    if (bus_rst) begin
      done_r <= 1'b0;
      act    <= 1'b0;
      mcnt   <= 0;
    end else if (bus_en) begin
      act  <= 1'b1;
      mcnt <= 1;
      if (lat == 1) done_r <= 1'b1;
    end else if (act) begin
      mcnt <= mcnt + 1;
      if (lat != 0 && mcnt + 1 == lat) done_r <= 1'b1;
    end
  end

  // Monitor: samples the cycle that is ending at each rising edge.
  int         cyc = 0;
  int         en_count = 0;
  int         en_cyc = 0;
  logic [3:0] en_cmd = '0;
  int         rsp_cyc = 0;
  logic [3:0] lq_cmd [$];
  logic       lq_to  [$];
  logic [7:0] lq_cyc [$];

  always @(posedge clk) begin
    if (bus_en) begin
      en_count = en_count + 1;
      en_cyc   = cyc;
      en_cmd   = bus_cmd;
    end
    if (rsp_valid) begin
      lq_cmd.push_back(rsp_cmd);
      lq_to.push_back(rsp_timeout);
      lq_cyc.push_back(rsp_cycles);
      rsp_cyc = cyc;
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] cmd);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Returns at the negedge of the REARM cycle following the awaited response.
  task automatic wait_rsp(input int target);
    int n = 0;
    while (lq_cmd.size() < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrived", {31'd0, (lq_cmd.size() >= target)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int i;
    int en_base;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_cmd   = '0;

    // Reset behaviour
    step(3);
    chk("bus_rst_in_reset", {31'd0, bus_rst}, 32'd1);
    chk("bus_en_in_reset", {31'd0, bus_en}, 32'd0);
    rst = 1'b0;
    step(1);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bus_cmd", {28'd0, bus_cmd}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_fields", {19'd0, rsp_cmd, rsp_timeout, rsp_cycles}, 32'd0);
    chk("rst_bus_rst_low", {31'd0, bus_rst}, 32'd0);

    // Single command, latency 17
    lat = 17;
    en_base = en_count;
    push(4'hA);
    wait_rsp(1);
    chk("single_en_count", en_count - en_base, 32'd1);
    chk("single_bus_cmd", {28'd0, en_cmd}, 32'hA);
    chk("single_rsp_cmd", {28'd0, lq_cmd[0]}, 32'hA);
    chk("single_rsp_timeout", {31'd0, lq_to[0]}, 32'd0);
    chk("single_rsp_cycles", {24'd0, lq_cyc[0]}, 32'd17);
    chk("single_rsp_latency", rsp_cyc - en_cyc, 32'd18);
    chk("single_bus_rst_pulse", {31'd0, bus_rst}, 32'd1);
    chk("single_rsp_hold", {24'd0, rsp_cycles}, 32'd17);
    step(1);
    chk("single_bus_rst_done", {31'd0, bus_rst}, 32'd0);
    chk("single_idle", {31'd0, busy}, 32'd0);
    chk("single_bus_cmd_hold", {28'd0, bus_cmd}, 32'hA);

    // Back-to-back 1..5 with latency 3; queue fills at 4 entries
    lat  = 3;
    base = lq_cmd.size();
    i = 1;
    while (i <= 5) begin
      req_valid = 1'b1;
      req_cmd   = 4'(i);
      if (req_ready) i++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_full_ready", {31'd0, req_ready}, 32'd0);
    chk("b2b_full_busy", {31'd0, busy}, 32'd1);
    req_valid = 1'b1;
    req_cmd   = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(base + 5);
    chk("b2b_last_rearm_busy", {31'd0, busy}, 32'd1);
    chk("b2b_last_rearm_rst", {31'd0, bus_rst}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("b2b_cmd%0d", k), {28'd0, lq_cmd[base+k]}, 32'(k + 1));
      chk($sformatf("b2b_cyc%0d", k), {23'd0, lq_to[base+k], lq_cyc[base+k]}, 32'd3);
    end
    step(1);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_no_extra", lq_cmd.size() - base, 32'd5);

    // Timeout: responder never answers
    lat  = 0;
    base = lq_cmd.size();
    push(4'h7);
    wait_rsp(base + 1);
    chk("to_rsp_cmd", {28'd0, lq_cmd[base]}, 32'h7);
    chk("to_rsp_timeout", {31'd0, lq_to[base]}, 32'd1);
    chk("to_rsp_cycles", {24'd0, lq_cyc[base]}, 32'd64);
    chk("to_rsp_latency", rsp_cyc - en_cyc, 32'd65);

    // Next command after a timeout issues normally
    lat = 2;
    push(4'h8);
    wait_rsp(base + 2);
    chk("after_to_cmd", {28'd0, lq_cmd[base+1]}, 32'h8);
    chk("after_to_fields", {23'd0, lq_to[base+1], lq_cyc[base+1]}, 32'd2);

    // Stuck done through issue
    lat   = 0;
    stuck = 1'b1;
    base  = lq_cmd.size();
    push(4'h9);
    wait_rsp(base + 1);
    chk("stuck_timeout", {31'd0, lq_to[base]}, 32'd1);
    chk("stuck_cycles", {24'd0, lq_cyc[base]}, 32'd64);
    chk("stuck_bus_rst", {31'd0, bus_rst}, 32'd1);
    stuck = 1'b0;
    step(2);

    // Done rises exactly at counter == TIMEOUT
    lat  = 64;
    base = lq_cmd.size();
    push(4'h5);
    wait_rsp(base + 1);
    chk("edge_timeout", {31'd0, lq_to[base]}, 32'd0);
    chk("edge_cycles", {24'd0, lq_cyc[base]}, 32'd64);

    // Done on the cycle before the limit
    lat  = 63;
    base = lq_cmd.size();
    push(4'h6);
    wait_rsp(base + 1);
    chk("edge63_fields", {23'd0, lq_to[base], lq_cyc[base]}, 32'd63);
    step(1);

    // Reset mid-WAIT with two commands still queued
    lat     = 0;
    base    = lq_cmd.size();
    en_base = en_count;
    push(4'hB);
    push(4'hC);
    push(4'hD);
    step(5);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step(1);
    chk("mid_bus_rst", {31'd0, bus_rst}, 32'd1);
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    step(1);
    chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_rsp_cmd", {28'd0, rsp_cmd}, 32'd0);
    step(100);
    chk("mid_no_rsp", lq_cmd.size() - base, 32'd0);
    chk("mid_single_issue", en_count - en_base, 32'd1);
    chk("mid_still_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simple_bus_master.md
Name: simple_bus_master

Overview:
- Initiator for the simple_bus command interface.
- Queues 4-bit commands from an upstream requester and issues each one to the responder as a one-cycle bus_en/bus_cmd strobe.
- Waits for the responder's done and reports completion or timeout upstream.
- Re-arms the responder, whose done is sticky, with a one-cycle bus_rst pulse after every transaction.

Parameters:
- CMD_W, 4: command width; must match the responder.
- FIFO_DEPTH, 4: request queue entries; power of two, at least 2.
- TIMEOUT, 64: maximum cycles after issue to wait for done.
- CNT_W, 8: width of the cycle counter and rsp_cycles; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  upstream command valid
- req_ready  out  1  queue can accept (not full)
- req_cmd  in  CMD_W  upstream command
- rsp_valid  out  1  one-cycle completion pulse
- rsp_cmd  out  CMD_W  command that completed
- rsp_timeout  out  1  1 = no done seen within TIMEOUT
- rsp_cycles  out  CNT_W  cycles from issue to done (TIMEOUT on timeout)
- bus_en  out  1  issue strobe to responder
- bus_cmd  out  CMD_W  command to responder
- bus_done  in  1  responder done (sticky until responder reset)
- bus_rst  out  1  responder reset
- busy  out  1  state != IDLE or queue non-empty

Behaviour:
- Interface (decided): reset rst, synchronous, active-high; clock clk.
- Reset values:
  - Queue emptied; state = IDLE.
  - bus_en = 0; bus_cmd = 0.
  - rsp_valid = 0; rsp_cmd = 0; rsp_timeout = 0; rsp_cycles = 0.
  - done_q = 0; counter = 0.
- bus_rst = rst OR (state == REARM), so the responder resets with the master.
- Reset mid-transaction aborts it silently: no rsp_valid, queued commands discarded.
- Queue:
  - Push when req_valid && req_ready; req_ready = !full.
  - Push and pop in the same cycle are allowed when not full.
  - A command pushed into an empty queue is poppable the next cycle (no bypass).
- done_q registers bus_done every cycle. done_rise = bus_done && !done_q.
- FSM states are IDLE, ISSUE, WAIT, RESP, REARM.
- IDLE:
  - If queue non-empty: pop head into cur_cmd, go to ISSUE.
  - Otherwise stay.
- ISSUE (cycle T):
  - bus_en = 1, bus_cmd = cur_cmd for exactly this cycle.
  - counter <= 1; go to WAIT.
- WAIT (cycle T+k, counter = k):
  - If done_rise: latch rsp_cycles = k, rsp_timeout = 0, go to RESP.
  - Else if k == TIMEOUT: latch rsp_cycles = TIMEOUT, rsp_timeout = 1, go to RESP.
  - Else counter increments.
  - If done_rise and k == TIMEOUT occur in the same cycle, done wins (rsp_timeout = 0).
- Done level at issue:
  - A bus_done already high at issue produces no done_rise and ends in timeout.
  - This is the required behaviour: it flags a responder that was not re-armed.
- RESP:
  - rsp_valid = 1 for one cycle with rsp_cmd = cur_cmd; no backpressure.
  - Response fields hold until the next RESP.
  - Go to REARM.
- REARM: bus_rst = 1 for one cycle; go to IDLE.
- Throughput: minimum 5 cycles per command (ISSUE, WAIT of 1 cycle, RESP, REARM, IDLE).
- bus_cmd holds its last value outside ISSUE; bus_en is never asserted outside ISSUE.

Decomposition:
- Package simple_bus_pkg:
  - State enum (IDLE, ISSUE, WAIT, RESP, REARM).
  - CMD_W default.
  - TIMEOUT default.
- Sub-module simple_bus_req_fifo:
  - Synchronous FIFO, parameters width and depth.
  - Ports: push, pop, full, empty.

Test Plan:
- Single command: push cmd 4'hA; responder model raises done 17 cycles after bus_en -> bus_en one cycle with bus_cmd = A; rsp_valid with rsp_cmd = A, rsp_timeout = 0, rsp_cycles = 17; bus_rst pulse the cycle after rsp_valid.
- Back-to-back: push 1, 2, 3, 4, 5 continuously with FIFO_DEPTH = 4 and model latency 3 -> req_ready drops when 4 are queued; responses in order 1..5, each rsp_cycles = 3; busy low only after the final REARM.
- Timeout: model never raises done -> rsp_timeout = 1, rsp_cycles = 64 at cycle T+64, rsp_valid at T+65; next command issues normally.
- Stuck done: hold bus_done high through issue -> no done_rise; timeout reported; bus_rst pulse follows.
- Boundary: done rises exactly at counter = TIMEOUT -> rsp_timeout = 0, rsp_cycles = 64.
- Reset mid-WAIT: assert rst with 2 commands queued -> no rsp_valid; bus_rst high during rst; queue empty; req_ready = 1; busy = 0 the cycle after rst deasserts.
